// File: rtl/axi_arb_pkg.sv
// Shared types for the cache-line arbiter slice.
//   state_e    : arbiter FSM states
//   master_e   : upstream requester identity (I-cache / D-cache)
//   req_type_e : downstream transfer direction
//   other_master() returns the requester that is not the argument; it is used
//   to rotate the round-robin pointer after each completed transfer.
package axi_arb_pkg;

  localparam int DEFAULT_LINE_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_e;

  typedef enum logic {
    M_I = 1'b0,
    M_D = 1'b1
  } master_e;

  typedef enum logic {
    RT_RD = 1'b0,
    RT_WR = 1'b1
  } req_type_e;

  function automatic master_e other_master(input master_e m);
    return (m == M_I) ? M_D : M_I;
  endfunction

endpackage

// File: rtl/axi_line_arbiter_if.sv
// Line-bus bundle around the arbiter: I-cache side (i_*), D-cache side (d_*)
// and the downstream line master side (ds_*).
//   slave  : view taken by the arbiter (serves the caches, drives the line master)
//   master : view taken by the surrounding caches / line master
interface axi_line_arbiter_if
  import axi_arb_pkg::*;
#(
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS
);

  logic [31:0]              i_addr;
  logic                     i_rd_req;
  logic                     i_gnt;
  logic [LINE_WORDS*32-1:0] i_rd_line;

  logic [31:0]              d_addr;
  logic                     d_rd_req;
  logic                     d_wr_req;
  logic [LINE_WORDS*32-1:0] d_wr_line;
  logic                     d_gnt;
  logic [LINE_WORDS*32-1:0] d_rd_line;

  logic [31:0]              ds_addr;
  logic                     ds_rd_req;
  logic                     ds_wr_req;
  logic [LINE_WORDS*32-1:0] ds_wr_line;
  logic                     ds_gnt;
  logic [LINE_WORDS*32-1:0] ds_rd_line;

  modport slave (
    input  i_addr, i_rd_req, d_addr, d_rd_req, d_wr_req, d_wr_line, ds_gnt, ds_rd_line,
    output i_gnt, i_rd_line, d_gnt, d_rd_line, ds_addr, ds_rd_req, ds_wr_req, ds_wr_line
  );

  modport master (
    output i_addr, i_rd_req, d_addr, d_rd_req, d_wr_req, d_wr_line, ds_gnt, ds_rd_line,
    input  i_gnt, i_rd_line, d_gnt, d_rd_line, ds_addr, ds_rd_req, ds_wr_req, ds_wr_line
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way winner selection.
//   req_i, req_d : requests from I-cache and D-cache
//   rr_ptr       : preferred master when both request and RR_ENABLE != 0
//   winner       : selected master (meaningful only when a request is present)
// With RR_ENABLE == 0 the D-cache wins every tie.
module rr_pick2
  import axi_arb_pkg::*;
#(
  parameter int RR_ENABLE = 1
) (
  input  logic    req_i,
  input  logic    req_d,
  input  master_e rr_ptr,
  output master_e winner
);

  // Tie-break between the two requesters
  always_comb begin
    winner = M_I;
    if (req_i && req_d) begin
      if (RR_ENABLE != 0) begin
        winner = rr_ptr;
      end else begin
        winner = M_D;
      end
    end else if (req_d) begin
      winner = M_D;
    end else begin
      winner = M_I;
    end
  end

endmodule

// File: rtl/axi_line_arbiter.sv
// Shares one cache-line master between the I-cache (read only) and the
// D-cache (read/write). A winner is picked in IDLE, its request is latched and
// presented downstream through ISSUE; the one-cycle ds_gnt is routed back as
// the winner's gnt, then a single GAP cycle keeps the line master from seeing
// a request right after its grant.
//   aclk, aresetn : clock, synchronous active-low reset
//   bus           : i_*/d_* upstream and ds_* downstream line signals
//   busy          : arbiter not in IDLE
//   err_timeout   : sticky, set when a transfer stays in ISSUE too long
module axi_line_arbiter
  import axi_arb_pkg::*;
#(
  parameter int LINE_WORDS     = DEFAULT_LINE_WORDS,
  parameter int RR_ENABLE      = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             aclk,
  input  logic             aresetn,
  axi_line_arbiter_if.slave bus,
  output logic             busy,
  output logic             err_timeout
);

  // A zero-width counter is illegal, so the disabled watchdog keeps one bit
  // pinned at zero (WD_MAX == 0 stops it from counting).
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_e                   state_r;
  state_e                   state_s;
  master_e                  sel_r;
  master_e                  rr_ptr_r;
  master_e                  win_s;
  req_type_e                pick_type_s;
  logic                     req_d_s;
  logic                     any_req_s;
  logic                     i_gnt_s;
  logic                     d_gnt_s;
  logic [31:0]              ds_addr_r;
  logic                     ds_rd_req_r;
  logic                     ds_wr_req_r;
  logic [LINE_WORDS*32-1:0] ds_wr_line_r;
  logic [WD_W-1:0]          wd_cnt_r;
  logic                     err_r;

  assign req_d_s     = bus.d_rd_req | bus.d_wr_req;
  assign any_req_s   = bus.i_rd_req | req_d_s;
  // A write from the D-cache overrides a simultaneous read request.
  assign pick_type_s = ((win_s == M_D) && bus.d_wr_req) ? RT_WR : RT_RD;

  rr_pick2 #(
    .RR_ENABLE(RR_ENABLE)
  ) u_pick (
    .req_i (bus.i_rd_req),
    .req_d (req_d_s),
    .rr_ptr(rr_ptr_r),
    .winner(win_s)
  );

  // FSM state register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and grant routing; grants are masked while reset is asserted so
  // a transfer killed by reset never reports completion.
  always_comb begin
    state_s = state_r;
    i_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (bus.ds_gnt) begin
          state_s = GAP;
          if (sel_r == M_I) begin
            i_gnt_s = aresetn;
          end else begin
            d_gnt_s = aresetn;
          end
        end else begin
          state_s = ISSUE;
        end
      end
      GAP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Request latch, round-robin pointer and watchdog
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sel_r        <= M_I;
      rr_ptr_r     <= M_I;
      ds_addr_r    <= 32'h0000_0000;
      ds_rd_req_r  <= 1'b0;
      ds_wr_req_r  <= 1'b0;
      ds_wr_line_r <= {(LINE_WORDS*32){1'b0}};
      wd_cnt_r     <= {WD_W{1'b0}};
      err_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            sel_r       <= win_s;
            ds_addr_r   <= (win_s == M_I) ? bus.i_addr : bus.d_addr;
            ds_rd_req_r <= (pick_type_s == RT_RD);
            ds_wr_req_r <= (pick_type_s == RT_WR);
            if (pick_type_s == RT_WR) begin
              ds_wr_line_r <= bus.d_wr_line;
            end
          end
        end
        ISSUE: begin
          if (wd_cnt_r != WD_MAX) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
          end
          // Flag only; the transfer keeps waiting for its grant.
          if ((TIMEOUT_CYCLES != 0) && (wd_cnt_r == WD_LAST)) begin
            err_r <= 1'b1;
          end
          if (bus.ds_gnt) begin
            ds_rd_req_r <= 1'b0;
            ds_wr_req_r <= 1'b0;
            rr_ptr_r    <= other_master(sel_r);
          end
        end
        GAP: begin
          wd_cnt_r <= {WD_W{1'b0}};
        end
        default: begin
          wd_cnt_r <= {WD_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.i_gnt      = i_gnt_s;
  assign bus.d_gnt      = d_gnt_s;
  assign bus.i_rd_line  = bus.ds_rd_line;
  assign bus.d_rd_line  = bus.ds_rd_line;
  assign bus.ds_addr    = ds_addr_r;
  assign bus.ds_rd_req  = ds_rd_req_r;
  assign bus.ds_wr_req  = ds_wr_req_r;
  assign bus.ds_wr_line = ds_wr_line_r;
  assign busy           = (state_r != IDLE);
  assign err_timeout    = err_r;

endmodule
